obi_mem_arbiter: RTL and testbench

//  Shares one downstream OBI data port (the TB memory model with random gnt/rvalid waits) among NREQ requesters.

---
 rtl/cheriot_dv_pkg.sv | 22 ++
 rtl/obi_id_fifo.sv | 42 ++++
 rtl/obi_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheriot_dv_pkg.sv
// Shared types for the OBI memory arbiter: FSM states, requester ID width and command bundle.
package cheriot_dv_pkg;

  localparam int unsigned ARB_ID_W   = 2;
  localparam int unsigned ARB_NMAX   = 1 << ARB_ID_W;
  localparam int unsigned ARB_DW_MAX = 65;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ARB  = 2'd1,
    ARB_HOLD = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  is_cap;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           addr;
    logic [ARB_DW_MAX-1:0] wdata;
  } arb_cmd_t;

endpackage

// File: rtl/obi_id_fifo.sv
// In-order requester-ID FIFO; extra pointer MSB distinguishes full from empty.
module obi_id_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_i)  rd_q <= rd_q + PTR_W'(1);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one OBI memory port among NREQ requesters with in-order response routing.
// Define OBI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round robin otherwise.
module obi_mem_arbiter
  import cheriot_dv_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DW     = 32,
  parameter int unsigned OUTSTD = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   host_req_i,
  input  logic [NREQ-1:0]   host_we_i,
  input  logic [NREQ*4-1:0] host_be_i,
  input  logic [NREQ-1:0]   host_is_cap_i,
  input  logic [NREQ*32-1:0] host_addr_i,
  input  logic [NREQ*DW-1:0] host_wdata_i,
  output logic [NREQ-1:0]   host_gnt_o,
  output logic [NREQ-1:0]   host_rvalid_o,
  output logic [DW-1:0]     host_rdata_o,
  output logic              host_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic              mem_is_cap_o,
  output logic [31:0]       mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [7:0]        mem_flag_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DW-1:0]     mem_rdata_i,
  input  logic              mem_err_i,
  output logic              proto_err_o
);

  localparam int unsigned PTR_W = $clog2(OUTSTD) + 1;

  arb_state_e          state_q;
  logic [ARB_ID_W-1:0] hold_id_q;
  logic [ARB_ID_W-1:0] base_id;
  logic [ARB_ID_W-1:0] win_id;
  logic [ARB_ID_W-1:0] cand;
  logic [ARB_ID_W-1:0] sel_id;
  logic [ARB_ID_W-1:0] fifo_head;
  logic [ARB_NMAX-1:0] req_pad;
  logic [PTR_W-1:0]    fifo_count;
  logic [PTR_W-1:0]    cnt_next;
  logic                found;
  logic                any_req;
  logic                slots_free;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                sel_we;
  logic                sel_is_cap;
  logic [3:0]          sel_be;
  logic [31:0]         sel_addr;
  logic [DW-1:0]       sel_wdata;

`ifdef OBI_ARB_FIXED_PRIO_EN
  assign base_id = '0;
`else
  logic [ARB_ID_W-1:0] rr_ptr_q;
  assign base_id = rr_ptr_q;
`endif

  assign req_pad = ARB_NMAX'(host_req_i);
  assign any_req = |host_req_i;

  // First requester found scanning upward from base_id, wrapping at NREQ.
  always_comb begin
    win_id = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ARB_ID_W'((32'(base_id) + i) % NREQ);
      if (!found && req_pad[cand]) begin
        win_id = cand;
        found  = 1'b1;
      end
    end
  end

  assign pop        = !rst_i && mem_rvalid_i && !fifo_empty;
  assign slots_free = (fifo_count < PTR_W'(OUTSTD)) || pop;
  assign sel_id     = (state_q == ARB_HOLD) ? hold_id_q : win_id;
  assign mem_req_o  = !rst_i && ((state_q == ARB_HOLD) || (any_req && slots_free));
  assign push       = mem_req_o && mem_gnt_i;
  assign cnt_next   = fifo_count + PTR_W'(push) - PTR_W'(pop);

  always_comb begin
    sel_we     = 1'b0;
    sel_is_cap = 1'b0;
    sel_be     = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_id == ARB_ID_W'(i)) begin
        sel_we     = host_we_i[i];
        sel_is_cap = host_is_cap_i[i];
        sel_be     = host_be_i[i*4 +: 4];
        sel_addr   = host_addr_i[i*32 +: 32];
        sel_wdata  = host_wdata_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      host_gnt_o[i]    = push && (sel_id == ARB_ID_W'(i));
      host_rvalid_o[i] = pop && (fifo_head == ARB_ID_W'(i));
    end
  end

  assign mem_we_o     = mem_req_o && sel_we;
  assign mem_is_cap_o = mem_req_o && sel_is_cap;
  assign mem_be_o     = mem_req_o ? sel_be : '0;
  assign mem_addr_o   = mem_req_o ? sel_addr : '0;
  assign mem_wdata_o  = mem_req_o ? sel_wdata : '0;
  assign mem_flag_o   = mem_req_o ? 8'(sel_id) : '0;
  assign host_rdata_o = rst_i ? '0 : mem_rdata_i;
  assign host_err_o   = !rst_i && mem_err_i;

  // Arbitration FSM; HOLD pins the winner until the memory grants it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      hold_id_q   <= '0;
      proto_err_o <= 1'b0;
`ifndef OBI_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      if (mem_rvalid_i && fifo_empty) proto_err_o <= 1'b1;
`ifndef OBI_ARB_FIXED_PRIO_EN
      if (push) rr_ptr_q <= (32'(sel_id) == NREQ - 1) ? '0 : sel_id + ARB_ID_W'(1);
`endif
      unique case (state_q)
        ARB_IDLE, ARB_ARB: begin
          if (mem_req_o && !mem_gnt_i) begin
            state_q   <= ARB_HOLD;
            hold_id_q <= win_id;
          end else begin
            state_q <= (any_req && (cnt_next < PTR_W'(OUTSTD))) ? ARB_ARB : ARB_IDLE;
          end
        end
        ARB_HOLD: begin
          if (mem_gnt_i) state_q <= (any_req && (cnt_next < PTR_W'(OUTSTD))) ? ARB_ARB : ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  obi_id_fifo #(
    .DEPTH (OUTSTD),
    .W     (ARB_ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel_id),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_obi_mem_arbiter;

  localparam int NREQ   = 2;
  localparam int DW     = 32;
  localparam int OUTSTD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NREQ-1:0]   host_req, host_we, host_is_cap;
  logic [NREQ*4-1:0] host_be;
  logic [NREQ*32-1:0] host_addr;
  logic [NREQ*DW-1:0] host_wdata;
  logic [NREQ-1:0]   host_gnt, host_rvalid;
  logic [DW-1:0]     host_rdata;
  logic              host_err;
  logic              mem_req, mem_we, mem_is_cap;
  logic [3:0]        mem_be;
  logic [31:0]       mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [7:0]        mem_flag;
  logic              mem_gnt, mem_rvalid, mem_err;
  logic [DW-1:0]     mem_rdata;
  logic              proto_err;

  obi_mem_arbiter #(.NREQ(NREQ), .DW(DW), .OUTSTD(OUTSTD)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
    .host_is_cap_i(host_is_cap), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .host_err_o(host_err), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_is_cap_o(mem_is_cap), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_flag_o(mem_flag), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .proto_err_o(proto_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outstanding IDs in order, pending (ungranted) winner, pointer, sticky error.
  int m_q[$];
  int m_rr;
  bit m_hold;
  int m_hold_id;
  bit m_perr;

  bit              e_req, e_pop;
  int              e_w;
  logic [NREQ-1:0] e_gnt, e_rv;
  logic [31:0]     e_addr;
  logic            e_we, e_cap;
  logic [3:0]      e_be;
  logic [DW-1:0]   e_wdata;
  logic [7:0]      e_flag;

  function automatic void model_clear();
    m_q.delete();
    m_rr = 0;
    m_hold = 1'b0;
    m_hold_id = 0;
    m_perr = 1'b0;
  endfunction

  function automatic void predict();
    int base, c;
    e_pop = mem_rvalid && (m_q.size() > 0);
`ifdef OBI_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = m_rr;
`endif
    if (m_hold) begin
      e_req = 1'b1;
      e_w   = m_hold_id;
    end else begin
      e_w   = 0;
      e_req = (|host_req) && ((m_q.size() < OUTSTD) || e_pop);
      for (int k = NREQ - 1; k >= 0; k--) begin
        c = (base + k) % NREQ;
        if (host_req[c]) e_w = c;
      end
    end
    e_gnt   = (e_req && mem_gnt) ? NREQ'(1 << e_w) : '0;
    e_rv    = e_pop ? NREQ'(1 << m_q[0]) : '0;
    e_addr  = e_req ? host_addr[e_w*32 +: 32] : '0;
    e_we    = e_req ? host_we[e_w] : 1'b0;
    e_cap   = e_req ? host_is_cap[e_w] : 1'b0;
    e_be    = e_req ? host_be[e_w*4 +: 4] : '0;
    e_wdata = e_req ? host_wdata[e_w*DW +: DW] : '0;
    e_flag  = e_req ? 8'(e_w) : '0;
  endfunction

  function automatic void commit();
    if (mem_rvalid && m_q.size() == 0) m_perr = 1'b1;
    if (e_pop) void'(m_q.pop_front());
    if (e_req && mem_gnt) begin
      m_q.push_back(e_w);
      m_rr   = (e_w + 1) % NREQ;
      m_hold = 1'b0;
    end else if (e_req) begin
      m_hold    = 1'b1;
      m_hold_id = e_w;
    end
  endfunction

  task automatic idle_inputs();
    host_req = '0; host_we = '0; host_is_cap = '0; host_be = '0;
    host_addr = '0; host_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic new_cmd(input int i);
    host_we[i]               = 1'($urandom_range(0, 1));
    host_is_cap[i]           = 1'($urandom_range(0, 1));
    host_be[i*4 +: 4]        = 4'($urandom);
    host_addr[i*32 +: 32]    = $urandom & 32'hFFFF_FFFC;
    host_wdata[i*DW +: DW]   = DW'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    host_req = '1; host_addr = {NREQ{32'h1234_5678}};
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #2;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    n_cmp++; if (host_gnt !== '0) begin n_err++; $display("FAIL reset_gnt got=%b exp=0", host_gnt); end
    n_cmp++; if (host_rvalid !== '0) begin n_err++; $display("FAIL reset_rvalid got=%b exp=0", host_rvalid); end
    n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    do_reset();
  endtask

  task automatic test_single_read();
    logic [31:0] a, d;
    do_reset();
    a = $urandom & 32'hFFFF_FFFC;
    d = $urandom;
    host_req = 2'b01; host_addr[31:0] = a; host_be[3:0] = 4'hF; mem_gnt = 1'b1;
    @(negedge clk); predict();
    n_cmp++; if (host_gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt got=%b exp=01", host_gnt); end
    n_cmp++; if (mem_addr !== a) begin n_err++; $display("FAIL single_addr got=%h exp=%h", mem_addr, a); end
    n_cmp++; if (mem_flag !== 8'd0) begin n_err++; $display("FAIL single_flag got=%0d exp=0", mem_flag); end
    commit();
    @(posedge clk); #1;
    host_req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d;
    @(negedge clk); predict();
    n_cmp++; if (host_rvalid !== 2'b01) begin n_err++; $display("FAIL single_rvalid got=%b exp=01", host_rvalid); end
    n_cmp++; if (host_rdata !== d) begin n_err++; $display("FAIL single_rdata got=%h exp=%h", host_rdata, d); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL single_req_after got=%b exp=0", mem_req); end
    commit();
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic test_alternate();
    logic [NREQ-1:0] exp_g;
    do_reset();
    host_req = 2'b11; mem_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); predict();
`ifdef OBI_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      n_cmp++; if (host_gnt !== exp_g) begin n_err++; $display("FAIL alt_gnt i=%0d got=%b exp=%b", i, host_gnt, exp_g); end
      n_cmp++; if (mem_flag !== 8'(exp_g[1])) begin n_err++; $display("FAIL alt_flag i=%0d got=%0d exp=%0d", i, mem_flag, exp_g[1]); end
      commit();
      @(posedge clk); #1;
    end
    host_req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_rdata = $urandom;
      @(negedge clk); predict();
      n_cmp++; if (host_rvalid !== e_rv) begin n_err++; $display("FAIL alt_drain i=%0d got=%b exp=%b", i, host_rvalid, e_rv); end
      commit();
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_hold_stable();
    logic [31:0] a1;
    logic [3:0]  b1;
    do_reset();
    a1 = $urandom & 32'hFFFF_FFFC;
    b1 = 4'($urandom_range(1, 15));
    host_req = 2'b10; host_addr[63:32] = a1; host_we[1] = 1'b1; host_be[7:4] = b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin host_req[0] = 1'b1; host_addr[31:0] = 32'hA5A5_0000; end
      mem_gnt = (i == 3);
      @(negedge clk); predict();
      n_cmp++; if ({mem_req, mem_addr, mem_we, mem_be, mem_flag} !== {1'b1, a1, 1'b1, b1, 8'd1}) begin
        n_err++; $display("FAIL hold_cmd i=%0d got=%b/%h/%b/%h/%0d exp=1/%h/1/%h/1", i, mem_req, mem_addr, mem_we, mem_be, mem_flag, a1, b1);
      end
      n_cmp++; if (host_gnt !== ((i == 3) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL hold_gnt i=%0d got=%b", i, host_gnt); end
      commit();
      @(posedge clk); #1;
    end
    host_req = '0; mem_gnt = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    host_req = 2'b01; mem_gnt = 1'b1;
    for (int i = 0; i < OUTSTD; i++) begin
      @(negedge clk); predict();
      n_cmp++; if (host_gnt !== 2'b01) begin n_err++; $display("FAIL full_fill i=%0d got=%b exp=01", i, host_gnt); end
      commit();
      @(posedge clk); #1;
    end
    @(negedge clk); predict();
    n_cmp++; if ({mem_req, host_gnt} !== 3'b000) begin n_err++; $display("FAIL full_block got=%b/%b exp=0/00", mem_req, host_gnt); end
    commit();
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = $urandom;
      @(negedge clk); predict();
      n_cmp++; if ({mem_req, host_gnt, host_rvalid} !== 5'b10101) begin
        n_err++; $display("FAIL full_pushpop i=%0d got=%b/%b/%b exp=1/01/01", i, mem_req, host_gnt, host_rvalid);
      end
      commit();
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    @(negedge clk); predict();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_still got=%b exp=0", mem_req); end
    commit();
    @(posedge clk); #1;
  endtask

  task automatic test_proto_err();
    do_reset();
    mem_rvalid = 1'b1;
    @(negedge clk); predict();
    n_cmp++; if ({host_rvalid, proto_err} !== 3'b000) begin n_err++; $display("FAIL perr_same got=%b/%b exp=00/0", host_rvalid, proto_err); end
    commit();
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky i=%0d got=%b exp=1", i, proto_err); end
      @(posedge clk); #1;
    end
    host_req = 2'b01; host_addr[31:0] = 32'h0000_1000; mem_gnt = 1'b0;
    @(negedge clk); predict();
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL perr_hold_req got=%b exp=1", mem_req); end
    commit();
    @(posedge clk); #1;
    mem_gnt = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_err = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({mem_req, host_gnt, proto_err, mem_addr, mem_flag} !== '0) begin
      n_err++; $display("FAIL rst_mid_hold got=%b/%b/%b/%h/%0d exp=all 0", mem_req, host_gnt, proto_err, mem_addr, mem_flag);
    end
    n_cmp++; if ({host_rdata, host_err} !== '0) begin n_err++; $display("FAIL rst_mid_hold_resp got=%h/%b exp=0/0", host_rdata, host_err); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk); predict();
      n_cmp++; if ({mem_req, host_gnt, host_rvalid, mem_flag} !== {e_req, e_gnt, e_rv, e_flag}) begin
        n_err++; $display("FAIL rnd_ctl cyc=%0d got=%b/%b/%b/%0d exp=%b/%b/%b/%0d", cyc, mem_req, host_gnt, host_rvalid, mem_flag, e_req, e_gnt, e_rv, e_flag);
      end
      n_cmp++; if ({mem_we, mem_is_cap, mem_be, mem_addr, mem_wdata} !== {e_we, e_cap, e_be, e_addr, e_wdata}) begin
        n_err++; $display("FAIL rnd_cmd cyc=%0d got=%b/%b/%h/%h/%h exp=%b/%b/%h/%h/%h", cyc, mem_we, mem_is_cap, mem_be, mem_addr, mem_wdata, e_we, e_cap, e_be, e_addr, e_wdata);
      end
      if (e_pop) begin
        n_cmp++; if ({host_rdata, host_err} !== {mem_rdata, mem_err}) begin
          n_err++; $display("FAIL rnd_resp cyc=%0d got=%h/%b exp=%h/%b", cyc, host_rdata, host_err, mem_rdata, mem_err);
        end
      end
      n_cmp++; if (proto_err !== m_perr) begin n_err++; $display("FAIL rnd_perr cyc=%0d got=%b exp=%b", cyc, proto_err, m_perr); end
      commit();
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (host_req[i] && e_gnt[i]) begin
          host_req[i] = 1'($urandom_range(0, 1));
          new_cmd(i);
        end else if (!host_req[i] && $urandom_range(0, 3) == 0) begin
          host_req[i] = 1'b1;
          new_cmd(i);
        end
      end
      mem_gnt    = ($urandom_range(0, 2) != 0);
      mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata  = DW'($urandom);
      mem_err    = ($urandom_range(0, 7) == 0);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_hold_stable();
    test_full();
    test_proto_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
